// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - decode-stage branch resolution controller driving the shared comparator
// Optional BRANCH_STAT_EN adds taken/not-taken/stall-cycle counters.
module branch_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [15:0]       br_imm,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic              rs_ready,
  input  logic              rt_ready,
  input  logic              flush,
  output logic [31:0]       judge_srca,
  output logic [31:0]       judge_srcb,
  output logic [3:0]        judge_op,
  input  logic              judge_res,
  output logic              stall_d,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_not_taken,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam logic [3:0] OP_EQ  = 4'd1;
  localparam logic [3:0] OP_NE  = 4'd2;
  localparam logic [3:0] OP_GTZ = 4'd3;
  localparam logic [3:0] OP_LEZ = 4'd4;
  localparam logic [3:0] OP_GEZ = 4'd5;
  localparam logic [3:0] OP_LTZ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    EVAL = 2'b10,
    DONE = 2'b11
  } stateT;

  stateT stateQ, stateNext;

  logic [3:0]        opQ;
  logic [ADDR_W-1:0] pcQ;
  logic [15:0]       immQ;
  logic [31:0]       rsQ, rtQ;
  logic              rsHave, rtHave;
  logic              takenQ;
  logic [ADDR_W-1:0] targetQ;
  logic              accept;
  logic              readyAtAccept;
  logic              readyInWait;
  logic [ADDR_W-1:0] offset;

  // Every valid comparator op reads rs, so needRs doubles as the op-valid test.
  function automatic logic needRs(input logic [3:0] op);
    case (op)
      OP_EQ, OP_NE, OP_GTZ, OP_LEZ, OP_GEZ, OP_LTZ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic needRt(input logic [3:0] op);
    return (op == OP_EQ) || (op == OP_NE);
  endfunction

  assign readyAtAccept = (!needRs(br_op) || rs_ready) && (!needRt(br_op) || rt_ready);
  assign readyInWait   = (!needRs(opQ) || rsHave || rs_ready) &&
                         (!needRt(opQ) || rtHave || rt_ready);
  assign offset        = ADDR_W'($signed({immQ, 2'b00}));

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  always_comb begin
    stateNext      = stateQ;
    accept         = 1'b0;
    br_ready       = 1'b0;
    stall_d        = 1'b0;
    redirect_valid = 1'b0;
    judge_op       = 4'b0;
    judge_srca     = 32'b0;
    judge_srcb     = 32'b0;
    case (stateQ)
      IDLE, DONE: begin
        br_ready       = 1'b1;
        redirect_valid = (stateQ == DONE) && takenQ;
        if (br_valid) begin
          accept    = 1'b1;
          stateNext = readyAtAccept ? EVAL : WAIT;
        end else begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        stall_d = 1'b1;
        if (readyInWait) begin
          stateNext = EVAL;
        end
      end
      EVAL: begin
        stall_d    = 1'b1;
        judge_op   = opQ;
        judge_srca = needRs(opQ) ? rsQ : 32'b0;
        judge_srcb = needRt(opQ) ? rtQ : 32'b0;
        stateNext  = DONE;
      end
      default: stateNext = IDLE;
    endcase
    // An abort drops any in-flight or newly presented branch and kills a pending redirect.
    if (flush) begin
      stateNext      = IDLE;
      accept         = 1'b0;
      redirect_valid = 1'b0;
    end
  end

  assign redirect_pc = targetQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      opQ     <= 4'b0;
      pcQ     <= '0;
      immQ    <= 16'b0;
      rsQ     <= 32'b0;
      rtQ     <= 32'b0;
      rsHave  <= 1'b0;
      rtHave  <= 1'b0;
      takenQ  <= 1'b0;
      targetQ <= '0;
    end else begin
      if (accept) begin
        opQ    <= br_op;
        pcQ    <= br_pc;
        immQ   <= br_imm;
        rsQ    <= rs_data;
        rtQ    <= rt_data;
        rsHave <= rs_ready;
        rtHave <= rt_ready;
      end else if (stateQ == WAIT) begin
        // Once an operand has been captured it is held, even if its ready flag drops.
        if (rs_ready && !rsHave) begin
          rsQ    <= rs_data;
          rsHave <= 1'b1;
        end
        if (rt_ready && !rtHave) begin
          rtQ    <= rt_data;
          rtHave <= 1'b1;
        end
      end
      if (stateQ == EVAL) begin
        takenQ  <= judge_res && needRs(opQ);
        targetQ <= pcQ + ADDR_W'(4) + offset;
      end
    end
  end

`ifdef BRANCH_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_taken        <= 32'b0;
      stat_not_taken    <= 32'b0;
      stat_stall_cycles <= 32'b0;
    end else begin
      if ((stateQ == DONE) && !flush) begin
        if (takenQ) begin
          stat_taken <= stat_taken + 32'd1;
        end else begin
          stat_not_taken <= stat_not_taken + 32'd1;
        end
      end
      if (stall_d) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - scoreboard bench for branch_ctrl with a behavioural comparator
module tb_branch_ctrl;

  localparam int ADDR_W = 32;
  localparam logic [3:0] OP_EQ  = 4'd1;
  localparam logic [3:0] OP_NE  = 4'd2;
  localparam logic [3:0] OP_GTZ = 4'd3;
  localparam logic [3:0] OP_LEZ = 4'd4;
  localparam logic [3:0] OP_GEZ = 4'd5;
  localparam logic [3:0] OP_LTZ = 4'd6;

  logic              clk = 1'b0;
  logic              reset;
  logic              br_valid;
  logic              br_ready;
  logic [3:0]        br_op;
  logic [ADDR_W-1:0] br_pc;
  logic [15:0]       br_imm;
  logic [31:0]       rs_data, rt_data;
  logic              rs_ready, rt_ready;
  logic              flush;
  logic [31:0]       judge_srca, judge_srcb;
  logic [3:0]        judge_op;
  logic              judge_res;
  logic              stall_d;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
`ifdef BRANCH_STAT_EN
  logic [31:0]       stat_taken, stat_not_taken, stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  branch_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_op(br_op),
    .br_pc(br_pc),
    .br_imm(br_imm),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .rs_ready(rs_ready),
    .rt_ready(rt_ready),
    .flush(flush),
    .judge_srca(judge_srca),
    .judge_srcb(judge_srcb),
    .judge_op(judge_op),
    .judge_res(judge_res),
    .stall_d(stall_d),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef BRANCH_STAT_EN
    ,
    .stat_taken(stat_taken),
    .stat_not_taken(stat_not_taken),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Behavioural stand-in for the core's combinational comparator.
  always_comb begin
    judge_res = 1'b0;
    case (judge_op)
      OP_EQ:   judge_res = (judge_srca == judge_srcb);
      OP_NE:   judge_res = (judge_srca != judge_srcb);
      OP_GTZ:  judge_res = ($signed(judge_srca) > 0);
      OP_LEZ:  judge_res = ($signed(judge_srca) <= 0);
      OP_GEZ:  judge_res = ($signed(judge_srca) >= 0);
      OP_LTZ:  judge_res = ($signed(judge_srca) < 0);
      default: judge_res = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passCnt = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } redirT;

  redirT expQ[$];
  int    stallCount = 0;
  logic  prevRedir = 1'b0;
  bit    monEn = 1'b0;

  always @(negedge clk) begin
    if (monEn) begin
      if (stall_d) stallCount++;
      if (redirect_valid) begin
        redirT e;
        check("redirect_nonconsecutive", 32'(prevRedir), 32'd0);
        check("redirect_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("redirect_cycle", cyc, e.cyc);
          check("redirect_pc", redirect_pc, e.pc);
        end
      end
      prevRedir = redirect_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic waitCyc(input int n);
    do @(negedge clk); while (cyc < n);
    #1;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setBr(input logic [3:0] op, input logic [31:0] pc, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr);
    br_valid = 1'b1;
    br_op    = op;
    br_pc    = pc;
    br_imm   = imm;
    rs_data  = rs;
    rt_data  = rt;
    rs_ready = rsr;
    rt_ready = rtr;
  endtask

  task automatic clrBr();
    br_valid = 1'b0;
    br_op    = 4'b0;
  endtask

  int t;
  int s0;

  initial begin
    reset = 1'b1;
    br_valid = 1'b0; br_op = 4'b0; br_pc = '0; br_imm = 16'b0;
    rs_data = 32'b0; rt_data = 32'b0; rs_ready = 1'b0; rt_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    monEn = 1'b1;
    waitCyc(cyc);
    check("reset_br_ready", 32'(br_ready), 32'd1);
    check("reset_stall_d", 32'(stall_d), 32'd0);
    check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_judge_op", 32'(judge_op), 32'd0);
    check("reset_judge_srca", judge_srca, 32'd0);
    check("reset_judge_srcb", judge_srcb, 32'd0);

    // Taken BEQ, then a second BEQ held on br_valid into DONE.
    nextCyc();
    t = cyc; s0 = stallCount;
    setBr(OP_EQ, 32'h3000, 16'h0004, 32'h5, 32'h5, 1'b1, 1'b1);
    expQ.push_back('{cyc: t + 2, pc: 32'h3014});
    nextCyc();
    setBr(OP_EQ, 32'h3004, 16'hFFFE, 32'h3, 32'h3, 1'b1, 1'b1);
    expQ.push_back('{cyc: t + 4, pc: 32'h3000});
    waitCyc(t + 1);
    check("eq_eval_judge_op", 32'(judge_op), 32'(OP_EQ));
    check("eq_eval_srca", judge_srca, 32'h5);
    check("eq_eval_br_ready", 32'(br_ready), 32'd0);
    check("eq_eval_stall", 32'(stall_d), 32'd1);
    nextCyc();
    waitCyc(t + 2);
    check("eq_done_br_ready", 32'(br_ready), 32'd1);
    check("eq_stall_cycles", stallCount - s0, 32'd1);
    nextCyc();
    clrBr();
    waitCyc(t + 4);
    check("b2b_stall_cycles", stallCount - s0, 32'd2);

    // NE with equal operands: not taken.
    nextCyc();
    t = cyc; s0 = stallCount;
    setBr(OP_NE, 32'h3100, 16'h0010, 32'h7, 32'h7, 1'b1, 1'b1);
    nextCyc();
    clrBr();
    waitCyc(t + 2);
    check("ne_done_br_ready", 32'(br_ready), 32'd1);
    check("ne_done_stall", 32'(stall_d), 32'd0);
    check("ne_stall_cycles", stallCount - s0, 32'd1);

    // LTZ waiting three cycles for rs; the stale value at accept must be replaced.
    nextCyc();
    nextCyc();
    t = cyc; s0 = stallCount;
    setBr(OP_LTZ, 32'h3010, 16'hFFFF, 32'h1, 32'h1234, 1'b0, 1'b0);
    expQ.push_back('{cyc: t + 5, pc: 32'h3010});
    nextCyc();
    clrBr();
    rs_data = 32'h2;
    waitCyc(t + 2);
    check("ltz_wait_br_ready", 32'(br_ready), 32'd0);
    check("ltz_wait_stall", 32'(stall_d), 32'd1);
    nextCyc();
    rs_ready = 1'b1;
    rs_data = 32'hFFFF_FFFF;
    nextCyc();
    rs_ready = 1'b0;
    rs_data = 32'h0;
    waitCyc(t + 4);
    check("ltz_eval_judge_op", 32'(judge_op), 32'(OP_LTZ));
    check("ltz_eval_srca", judge_srca, 32'hFFFF_FFFF);
    check("ltz_eval_srcb", judge_srcb, 32'h0);
    waitCyc(t + 5);
    check("ltz_stall_cycles", stallCount - s0, 32'd4);

    // GTZ flushed during EVAL: no redirect, ready again next cycle.
    nextCyc();
    nextCyc();
    t = cyc; s0 = stallCount;
    setBr(OP_GTZ, 32'h4000, 16'h0008, 32'h5, 32'h0, 1'b1, 1'b0);
    nextCyc();
    clrBr();
    flush = 1'b1;
    nextCyc();
    flush = 1'b0;
    waitCyc(t + 2);
    check("gtz_flush_br_ready", 32'(br_ready), 32'd1);
    check("gtz_flush_stall", 32'(stall_d), 32'd0);
    check("gtz_flush_redirect", 32'(redirect_valid), 32'd0);
    check("gtz_stall_cycles", stallCount - s0, 32'd1);

    // Taken EQ flushed in DONE: redirect suppressed.
    nextCyc();
    t = cyc; s0 = stallCount;
    setBr(OP_EQ, 32'h6000, 16'h0000, 32'h1, 32'h1, 1'b1, 1'b1);
    nextCyc();
    clrBr();
    nextCyc();
    flush = 1'b1;
    waitCyc(t + 2);
    check("done_flush_redirect", 32'(redirect_valid), 32'd0);
    nextCyc();
    flush = 1'b0;
    waitCyc(t + 3);
    check("done_flush_after", 32'(redirect_valid), 32'd0);
    check("done_flush_br_ready", 32'(br_ready), 32'd1);

`ifdef BRANCH_STAT_EN
    check("stat_taken", stat_taken, 32'd3);
    check("stat_not_taken", stat_not_taken, 32'd1);
    check("stat_stall_cycles", stat_stall_cycles, stallCount);
`endif
    check("total_stall_cycles", stallCount, 32'd9);

    // Unknown op with nothing ready: goes straight to EVAL and resolves not taken.
    nextCyc();
    t = cyc;
    setBr(4'hF, 32'h7000, 16'h0004, 32'h1, 32'h1, 1'b0, 1'b0);
    nextCyc();
    clrBr();
    waitCyc(t + 1);
    check("unk_eval_stall", 32'(stall_d), 32'd1);
    waitCyc(t + 2);
    check("unk_done_br_ready", 32'(br_ready), 32'd1);

    repeat (4) nextCyc();
    waitCyc(cyc);
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Decode-stage branch resolution controller for the pipelined MIPS core. It accepts one conditional branch at a time and waits, stalling decode, until the hazard unit reports the needed register operands ready. It then drives the existing combinational branch comparator (SrcA/SrcB/JudgeOp → JudgeRes) from registered operands and issues a one-cycle PC redirect for taken branches. It owns the comparator exclusively; no other requester drives it.

## Interface
Parameters:
- `ADDR_W`, 32: PC width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `br_valid` in 1: decode presents a branch.
- `br_ready` out 1: controller can accept a branch.
- `br_op` in 4: comparator op code (`EQ`, `NE`, `GTZ`, `LEZ`, `GEZ`, `LTZ` from macro.vh).
- `br_pc` in ADDR_W: PC of the branch.
- `br_imm` in 16: signed word offset.
- `rs_data`, `rt_data` in 32: forwarded operand values, valid when the matching ready is high.
- `rs_ready`, `rt_ready` in 1: hazard unit operand-ready flags.
- `flush` in 1: exception/ERET abort.
- `judge_srca`, `judge_srcb` out 32: to comparator SrcA/SrcB.
- `judge_op` out 4: to comparator JudgeOp.
- `judge_res` in 1: comparator JudgeRes (combinational from the three outputs above).
- `stall_d` out 1: freeze F/D registers.
- `redirect_valid` out 1: one-cycle taken pulse.
- `redirect_pc` out ADDR_W: branch target.

## Operation
- States: IDLE, WAIT, EVAL, DONE. Two-bit encoding; all outputs decoded from registered state and registered operand/op registers.
- Operand need: `EQ`/`NE` need rs and rt; `GTZ`/`LEZ`/`GEZ`/`LTZ` need rs only, and `judge_srcb` is driven 0. Any other op code needs no operands and always resolves not taken.
- IDLE: `br_ready`=1, `stall_d`=0. On `br_valid`, latch op, pc, and imm. Capture rs_data/rt_data unconditionally. If the needed operands are ready, go to EVAL; otherwise go to WAIT.
- WAIT: `stall_d`=1, `br_ready`=0. Re-capture each operand whose ready flag is high every cycle; a captured operand stays held. When all needed operands have been captured, go to EVAL.
- EVAL: `stall_d`=1. Comparator inputs come from registers. Sample `judge_res` into `taken_q`. Compute target = br_pc + 4 + (sign-extend(br_imm) << 2), truncated to ADDR_W and wrapping modulo 2^ADDR_W. Go to DONE.
- DONE: `stall_d`=0, `redirect_valid`=taken_q, `redirect_pc`=target. If `br_valid` is high, a new branch is accepted this cycle exactly as in IDLE, so back-to-back branches are allowed. Otherwise go to IDLE.
- `flush` overrides every state: next state is IDLE, and no redirect is emitted in the next cycle. If DONE and `flush` occur in the same cycle, `redirect_valid` is forced to 0.
- `judge_op` is driven with the latched op only in EVAL; otherwise it is 4'b0 (not a valid op), so `judge_res` reads 0.

## Timing
- Reset values: state=IDLE, `br_ready`=1, `stall_d`=0, `redirect_valid`=0, `redirect_pc`=0, `judge_srca`=`judge_srcb`=0, `judge_op`=0, all internal registers 0.
- `reset` mid-operation abandons the branch with no redirect; `reset` has priority over `flush`.
- Latency with operands ready at accept: accept in cycle T, EVAL at T+1, redirect at T+2. `stall_d` is high for 1 cycle.
- Each extra cycle in WAIT adds one cycle to redirect latency and to stall.
- `redirect_valid` is never high for two consecutive cycles.
- Delay-slot handling is owned by fetch; this block only supplies the target.

## Configuration
- `BRANCH_STAT_EN` defined: adds 32-bit output counters `stat_taken`, `stat_not_taken`, `stat_stall_cycles`, all reset to 0. The two outcome counters increment in DONE unless `flush`. The stall counter increments every cycle `stall_d`=1. All counters wrap at 2^32.
- `BRANCH_STAT_EN` undefined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- `EQ`, rs=rt=0x5, both ready, pc=0x3000, imm=0x0004 → `redirect_valid`=1 two cycles after accept, `redirect_pc`=0x3014, `stall_d` high for 1 cycle.
- `NE`, rs=rt=0x7 → no redirect; DONE reached at T+2; `br_ready` high again at T+2.
- `LTZ`, rs=0xFFFFFFFF, rs_ready low for 3 cycles, imm=0xFFFF, pc=0x3010 → 3 WAIT cycles, redirect at T+5 to 0x3010; `stall_d` high for 4 cycles.
- `GTZ` accepted, `flush` asserted during EVAL → next state IDLE, no redirect pulse, `br_ready`=1 the next cycle.
- Back-to-back: `BEQ` taken followed by `br_valid` held in DONE → second branch accepted at T+2, redirect pulses at T+2 and T+4, never on consecutive cycles.
- With `BRANCH_STAT_EN`: the sequence above yields `stat_taken`=3, `stat_not_taken`=1, and `stat_stall_cycles` equal to the bench's count of `stall_d` high cycles.
